chip8_loader: RTL

CHIP8_LOADER -- requirements
Module: chip8_loader

---
 rtl/chip8_loader_if.sv | 30 +++
 rtl/chip8_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/chip8_loader_if.sv
// Host byte stream plus the two memory write ports of the CHIP-8 loader.
// Stream handshake: a byte moves on a rising cpu_clk edge exactly when
// in_valid and in_ready are both high; in_ready never depends on in_valid,
// and in_last is only meaningful on a cycle where in_valid is high.
interface chip8_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [11:0] mem_addr1;
    logic [11:0] mem_addr2;
    logic [7:0]  mem_wdata1;
    logic [7:0]  mem_wdata2;
    logic        mem_we1;
    logic        mem_we2;

    // Host side: drives the stream, observes readiness and memory writes.
    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2,
               mem_we1, mem_we2
    );

    // Loader side: consumes the stream, drives the memory write ports.
    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2,
               mem_we1, mem_we2
    );
endinterface

// File: rtl/chip8_loader.sv
// CHIP-8 loader: on start, writes the 80-byte hex font to 0x000-0x04F two
// bytes per cycle, then streams program bytes into 0x200 upward, one per
// cycle, until the last byte or until memory ends at 0xFFF.
module chip8_loader (
    input  logic               cpu_clk,
    input  logic               reset,
    input  logic               start,
    chip8_loader_if.slave      bus,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [11:0]        byte_count,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FONT = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Standard CHIP-8 hex glyphs, digits 0-F, five rows each.
    localparam logic [0:79][7:0] FONT_ROM = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

    localparam logic [5:0]  LAST_FONT_K = 6'd39;
    localparam logic [11:0] LOAD_BASE   = 12'h200;
    localparam logic [11:0] LAST_SLOT   = 12'hDFF;  // count before the 0xFFF byte

    state_t     state;
    logic [5:0] font_k;      // index of the font pair currently on the ports
    logic [5:0] font_next;   // pair to present after the coming edge
    logic       font_wr;     // a font pair is registered on the coming edge
    logic       start_ok;
    logic       accept;

    // Stream readiness is a pure state decode so no path exists from in_valid.
    assign bus.in_ready = (state == S_LOAD);
    assign busy         = (state == S_FONT) || (state == S_LOAD);
    assign done         = (state == S_DONE);
    assign state_dbg    = state;

    // Next font pair: entry presents pair 0, each FONT cycle advances one pair.
    always_comb begin
        start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
        accept    = bus.in_valid && (state == S_LOAD);
        font_next = 6'd0;
        if (state == S_FONT) begin
            font_next = font_k + 6'd1;
        end
        font_wr = start_ok || ((state == S_FONT) && (font_k != LAST_FONT_K));
    end

    // Sequencer plus registered memory ports; ports idle at zero unless written.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            font_k         <= 6'd0;
            byte_count     <= 12'd0;
            overflow       <= 1'b0;
            bus.mem_we1    <= 1'b0;
            bus.mem_we2    <= 1'b0;
            bus.mem_addr1  <= 12'd0;
            bus.mem_addr2  <= 12'd0;
            bus.mem_wdata1 <= 8'd0;
            bus.mem_wdata2 <= 8'd0;
        end else begin
            bus.mem_we1    <= 1'b0;
            bus.mem_we2    <= 1'b0;
            bus.mem_addr1  <= 12'd0;
            bus.mem_addr2  <= 12'd0;
            bus.mem_wdata1 <= 8'd0;
            bus.mem_wdata2 <= 8'd0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state      <= S_FONT;
                        font_k     <= 6'd0;
                        byte_count <= 12'd0;
                        overflow   <= 1'b0;
                    end
                end
                S_FONT: begin
                    if (font_k == LAST_FONT_K) begin
                        state <= S_LOAD;
                    end else begin
                        font_k <= font_next;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        bus.mem_we1    <= 1'b1;
                        bus.mem_addr1  <= LOAD_BASE + byte_count;
                        bus.mem_wdata1 <= bus.in_data;
                        byte_count     <= byte_count + 12'd1;
                        // The 0xFFF byte ends the load; without in_last it overflowed.
                        if (bus.in_last || (byte_count == LAST_SLOT)) begin
                            state    <= S_DONE;
                            overflow <= ~bus.in_last;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (font_wr) begin
                bus.mem_we1    <= 1'b1;
                bus.mem_we2    <= 1'b1;
                bus.mem_addr1  <= {5'd0, font_next, 1'b0};
                bus.mem_addr2  <= {5'd0, font_next, 1'b1};
                bus.mem_wdata1 <= FONT_ROM[{font_next, 1'b0}];
                bus.mem_wdata2 <= FONT_ROM[{font_next, 1'b1}];
            end
        end
    end

endmodule
